dual_fetch: RTL and testbench

Dual-issue instruction fetch stage of the in-order superscalar CPU, sitting directly upstream of the dual decoder. It generates instruction-memory pair addresses and buffers returned instructions in a small circular queue. Each cycle it presents the two oldest instructions, with their PCs, to decode. Decode may consume 0, 1 or 2 of them, which absorbs the single-issue stalls that decode imposes on dependent pairs. Branch/jump redirects flush the queue and discard any in-flight fetch.

---
 rtl/dual_fetch.sv | 122 ++++++++++++
 tb/tb_dual_fetch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dual_fetch.sv
// Dual-issue fetch: issues instruction-memory pair reads and buffers the returned words in a
// circular queue, presenting the two oldest to decode, which may take 0, 1 or 2 per cycle.
module dual_fetch #(
  parameter int AW     = 16,
  parameter int QDEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          im_re,
  output logic [AW-2:0] im_addr,
  input  logic [63:0]   im_rdata,
  input  logic [1:0]    consume,
  input  logic          flow_change,
  input  logic [AW-1:0] dst_pc,
  input  logic          halt,
  output logic [31:0]   instr0,
  output logic [31:0]   instr1,
  output logic [AW-1:0] pc0,
  output logic [AW-1:0] pc1,
  output logic          vld0,
  output logic          vld1
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] pc;
  logic [31:0]   q_instr [QDEPTH];
  logic [AW-1:0] q_pc    [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          inflight;
  logic          inflight_odd;
  logic [AW-1:0] inflight_pc;
  logic          halted;

  logic [1:0]    want;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wr_cnt;
  logic [CW:0]   occ_next;
  logic [PW-1:0] rd_ptr1;
  logic [PW-1:0] wr_ptr1;
  logic [31:0]   wr0_instr;
  logic [AW-1:0] wr0_pc;
  logic [AW-1:0] wr1_pc;

  always_comb begin
    want = (consume == 2'd3) ? 2'd2 : consume;
    rd_cnt = (count < CW'(want)) ? count : CW'(want);
    wr_cnt = '0;
    if (inflight) wr_cnt = inflight_odd ? CW'(1) : CW'(2);
    occ_next = {1'b0, count} + {1'b0, wr_cnt} - {1'b0, rd_cnt};
  end

  // Decision uses the occupancy after this cycle's write and read, so consume is on the im_re path.
  assign im_re   = rst_n & ~halted & ~flow_change & (occ_next <= (CW+1)'(QDEPTH - 2));
  assign im_addr = pc[AW-1:1];

  // An odd request returns a pair whose even word precedes the target and is dropped.
  assign wr0_instr = inflight_odd ? im_rdata[63:32] : im_rdata[31:0];
  assign wr0_pc    = inflight_pc;
  assign wr1_pc    = inflight_pc + AW'(1);
  assign wr_ptr1   = wr_ptr + PW'(1);
  assign rd_ptr1   = rd_ptr + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      inflight     <= 1'b0;
      inflight_odd <= 1'b0;
      inflight_pc  <= '0;
      halted       <= 1'b0;
    end else begin
      if (halt) halted <= 1'b1;
      if (flow_change) begin
        pc       <= dst_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        inflight <= 1'b0;
      end else begin
        rd_ptr       <= rd_ptr + PW'(rd_cnt);
        wr_ptr       <= wr_ptr + PW'(wr_cnt);
        count        <= occ_next[CW-1:0];
        inflight     <= im_re;
        inflight_odd <= pc[0];
        inflight_pc  <= pc;
        if (im_re) pc <= (pc | AW'(1)) + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (!flow_change && inflight) begin
      q_instr[wr_ptr] <= wr0_instr;
      q_pc[wr_ptr]    <= wr0_pc;
      if (!inflight_odd) begin
        q_instr[wr_ptr1] <= im_rdata[63:32];
        q_pc[wr_ptr1]    <= wr1_pc;
      end
    end
  end

  assign instr0 = q_instr[rd_ptr];
  assign instr1 = q_instr[rd_ptr1];
  assign pc0    = q_pc[rd_ptr];
  assign pc1    = q_pc[rd_ptr1];
  assign vld0   = (count != '0);
  assign vld1   = (count >= CW'(2));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(QDEPTH));

endmodule

// File: tb/tb_dual_fetch.sv
// Randomized bench for dual_fetch: a queue-level model of the fetch stream is checked every cycle.
module tb_dual_fetch;
  localparam int AW = 16;
  localparam int QD = 4;

  logic          clk;
  logic          rst_n;
  logic          im_re;
  logic [AW-2:0] im_addr;
  logic [63:0]   im_rdata;
  logic [1:0]    consume;
  logic          flow_change;
  logic [AW-1:0] dst_pc;
  logic          halt;
  logic [31:0]   instr0, instr1;
  logic [AW-1:0] pc0, pc1;
  logic          vld0, vld1;

  int vectors = 0;
  int errors  = 0;

  dual_fetch #(.AW(AW), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .im_re(im_re), .im_addr(im_addr), .im_rdata(im_rdata),
    .consume(consume), .flow_change(flow_change), .dst_pc(dst_pc), .halt(halt),
    .instr0(instr0), .instr1(instr1), .pc0(pc0), .pc1(pc1), .vld0(vld0), .vld1(vld1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(logic [AW-1:0] a);
    return 32'hA000_0000 | {16'h0000, a};
  endfunction

  // Memory answers one cycle after a request; otherwise the bus carries junk.
  always @(posedge clk) begin
    if (im_re) im_rdata <= {mem_word({im_addr, 1'b1}), mem_word({im_addr, 1'b0})};
    else       im_rdata <= {$urandom, $urandom};
  end

  // Reference model: buffered PCs visible to decode, PCs arriving next cycle, next fetch PC.
  logic [AW-1:0] m_buf[$];
  logic [AW-1:0] m_pend[$];
  logic [AW-1:0] m_pc;
  bit            m_halted;

  function automatic int m_take();
    int c;
    c = (consume == 2'd3) ? 2 : int'(consume);
    return (c < m_buf.size()) ? c : m_buf.size();
  endfunction

  function automatic bit m_req();
    return rst_n && !m_halted && !flow_change &&
           (m_buf.size() + m_pend.size() - m_take() <= QD - 2);
  endfunction

  initial begin
    m_pc = '0;
    m_halted = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_buf.delete();
        m_pend.delete();
        m_pc = '0;
        m_halted = 0;
      end else begin
        bit req;
        int take;
        req  = m_req();
        take = m_take();
        if (flow_change) begin
          m_buf.delete();
          m_pend.delete();
          m_pc = dst_pc;
        end else begin
          repeat (take) void'(m_buf.pop_front());
          foreach (m_pend[i]) m_buf.push_back(m_pend[i]);
          m_pend.delete();
          if (req) begin
            m_pend.push_back(m_pc);
            if (!m_pc[0]) m_pend.push_back(m_pc + AW'(1));
            m_pc = (m_pc | AW'(1)) + AW'(1);
          end
        end
        if (halt) m_halted = 1;
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the model mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("vld0", 64'(vld0), 64'(m_buf.size() >= 1));
      chk("vld1", 64'(vld1), 64'(m_buf.size() >= 2));
      if (m_buf.size() >= 1) begin
        chk("pc0", 64'(pc0), 64'(m_buf[0]));
        chk("instr0", 64'(instr0), 64'(mem_word(m_buf[0])));
      end
      if (m_buf.size() >= 2) begin
        chk("pc1", 64'(pc1), 64'(m_buf[1]));
        chk("instr1", 64'(instr1), 64'(mem_word(m_buf[1])));
      end
      chk("im_re", 64'(im_re), 64'(m_req()));
      if (m_req()) chk("im_addr", 64'(im_addr), 64'(m_pc[AW-1:1]));
      if (!rst_n) chk("im_addr_rst", 64'(im_addr), 64'(0));
    end
  end

  task automatic drive(int cons, bit fc, logic [AW-1:0] dst, bit h);
    consume     = 2'(cons);
    flow_change = fc;
    dst_pc      = dst;
    halt        = h;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    drive(0, 0, '0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    consume     = '0;
    flow_change = 1'b0;
    dst_pc      = '0;
    halt        = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (20) drive(2, 0, '0, 0);                 // straight-line, full rate
    repeat (24) drive(1, 0, '0, 0);                 // single issue
    repeat (10) drive(0, 0, '0, 0);                 // backpressure
    repeat (10) drive(2, 0, '0, 0);
    repeat (6)  drive(0, 0, '0, 0);                 // fill, then odd redirect
    drive(0, 1, 16'h0025, 0);
    repeat (3)  drive(0, 0, '0, 0);
    repeat (8)  drive(2, 0, '0, 0);
    repeat (5)  drive(2, 0, '0, 0);                 // redirect while a response returns
    drive(2, 1, 16'h0100, 0);
    repeat (6)  drive(1, 0, '0, 0);
    drive(1, 0, '0, 1);                             // halt and drain
    repeat (10) drive(1, 0, '0, 0);
    drive(0, 1, 16'h0040, 0);
    repeat (4)  drive(1, 0, '0, 0);
    rst_pulse();
    repeat (8)  drive(2, 0, '0, 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0 || (m_halted && $urandom_range(0, 19) == 0))
        rst_pulse();
      else
        drive(int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
              AW'($urandom), ($urandom_range(0, 399) == 0));
    end

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
